// File: rtl/stride_detector_if.sv
// Observation bus and stride-context outputs between the AR snoop point,
// the stride detector and the prefetcher controller.
interface stride_detector_if #(
    parameter int ADDR_BITS = 64,
    parameter int TID_WIDTH = 4,
    parameter int CONF_BITS = 3
);
    logic                 obs_valid;
    logic [ADDR_BITS-1:0] obs_addr;
    logic [TID_WIDTH-1:0] obs_id;
    logic                 ctx_valid;
    logic                 stride_locked;
    logic [ADDR_BITS-1:0] stride;
    logic [ADDR_BITS-1:0] base_addr;
    logic [TID_WIDTH-1:0] tag_id;
    logic [CONF_BITS-1:0] conf;
    logic                 stride_change;

    // Observation source / context consumer side
    modport master (
        output obs_valid, obs_addr, obs_id,
        input  ctx_valid, stride_locked, stride, base_addr, tag_id, conf, stride_change
    );

    // Stride detector side
    modport slave (
        input  obs_valid, obs_addr, obs_id,
        output ctx_valid, stride_locked, stride, base_addr, tag_id, conf, stride_change
    );
endinterface

// File: rtl/stride_detector.sv
// Stride detector: trains on accepted in-range AR requests of a single ID and
// locks onto a constant signed address stride. Once locked it presents stride,
// base address and tag so the prefetcher controller can issue bursts.
module stride_detector #(
    parameter int ADDR_BITS   = 64,
    parameter int TID_WIDTH   = 4,
    parameter int CONF_BITS   = 3,
    parameter int CONF_THRESH = 3,
    parameter int MAX_STRIDE  = 4096
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             en,
    input  logic             flush,
    stride_detector_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FIRST  = 2'd1;
    localparam logic [1:0] ST_TRAIN  = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam logic [CONF_BITS-1:0] CONF_ZERO = {CONF_BITS{1'b0}};
    localparam logic [CONF_BITS-1:0] CONF_ONE  = CONF_BITS'(1);
    localparam logic [CONF_BITS-1:0] CONF_MAX  = {CONF_BITS{1'b1}};
    localparam logic [CONF_BITS-1:0] CONF_LOCK = CONF_BITS'(CONF_THRESH);
    localparam logic [ADDR_BITS-1:0] ADDR_ZERO = {ADDR_BITS{1'b0}};
    localparam logic [ADDR_BITS-1:0] STRIDE_LIMIT = ADDR_BITS'(MAX_STRIDE);

    // Magnitude of a two's-complement delta. The most negative value maps to
    // itself, which still compares as huge (far) in the unsigned compare.
    function automatic logic [ADDR_BITS-1:0] abs_delta(input logic [ADDR_BITS-1:0] d);
        if (d[ADDR_BITS-1]) begin
            abs_delta = ~d + {{(ADDR_BITS-1){1'b0}}, 1'b1};
        end else begin
            abs_delta = d;
        end
    endfunction

    // Confidence increment that sticks at the all-ones value.
    function automatic logic [CONF_BITS-1:0] conf_sat_inc(input logic [CONF_BITS-1:0] c);
        if (c == CONF_MAX) begin
            conf_sat_inc = CONF_MAX;
        end else begin
            conf_sat_inc = c + CONF_ONE;
        end
    endfunction

    logic [1:0]           state_r;
    logic [ADDR_BITS-1:0] stride_r;
    logic [ADDR_BITS-1:0] base_r;
    logic [TID_WIDTH-1:0] tag_r;
    logic [CONF_BITS-1:0] conf_r;
    logic                 chg_r;
    logic                 ctx_r;
    logic                 locked_r;

    logic [ADDR_BITS-1:0] delta_s;
    logic                 far_s;
    logic                 id_miss_s;
    logic                 zero_s;
    logic                 match_s;
    logic [CONF_BITS-1:0] conf_inc_s;

    logic [1:0]           state_nxt_s;
    logic [ADDR_BITS-1:0] stride_nxt_s;
    logic [ADDR_BITS-1:0] base_nxt_s;
    logic [TID_WIDTH-1:0] tag_nxt_s;
    logic [CONF_BITS-1:0] conf_nxt_s;
    logic                 chg_nxt_s;

    // Delta against the last matching address, wrapping modulo 2^ADDR_BITS.
    always_comb begin
        delta_s    = bus.obs_addr - base_r;
        far_s      = (abs_delta(delta_s) > STRIDE_LIMIT);
        id_miss_s  = (bus.obs_id != tag_r);
        zero_s     = (delta_s == ADDR_ZERO);
        match_s    = (delta_s == stride_r);
        conf_inc_s = conf_sat_inc(conf_r);
    end

    // Training FSM next-state and context update for one observation.
    always_comb begin
        state_nxt_s  = state_r;
        stride_nxt_s = stride_r;
        base_nxt_s   = base_r;
        tag_nxt_s    = tag_r;
        conf_nxt_s   = conf_r;
        chg_nxt_s    = 1'b0;
        if (bus.obs_valid) begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s  = ST_FIRST;
                    tag_nxt_s    = bus.obs_id;
                    base_nxt_s   = bus.obs_addr;
                    stride_nxt_s = ADDR_ZERO;
                    conf_nxt_s   = CONF_ZERO;
                end
                ST_FIRST: begin
                    if (id_miss_s || far_s) begin
                        // Restart context on the new stream
                        state_nxt_s  = ST_FIRST;
                        tag_nxt_s    = bus.obs_id;
                        base_nxt_s   = bus.obs_addr;
                        stride_nxt_s = ADDR_ZERO;
                        conf_nxt_s   = CONF_ZERO;
                    end else if (zero_s) begin
                        state_nxt_s = ST_FIRST;
                    end else begin
                        state_nxt_s  = ST_TRAIN;
                        base_nxt_s   = bus.obs_addr;
                        stride_nxt_s = delta_s;
                        conf_nxt_s   = CONF_ONE;
                    end
                end
                ST_TRAIN: begin
                    if (id_miss_s || far_s) begin
                        state_nxt_s  = ST_FIRST;
                        tag_nxt_s    = bus.obs_id;
                        base_nxt_s   = bus.obs_addr;
                        stride_nxt_s = ADDR_ZERO;
                        conf_nxt_s   = CONF_ZERO;
                    end else if (zero_s) begin
                        state_nxt_s = ST_TRAIN;
                    end else if (match_s) begin
                        base_nxt_s = bus.obs_addr;
                        conf_nxt_s = conf_inc_s;
                        if (conf_inc_s >= CONF_LOCK) begin
                            state_nxt_s = ST_LOCKED;
                        end else begin
                            state_nxt_s = ST_TRAIN;
                        end
                    end else begin
                        state_nxt_s  = ST_TRAIN;
                        base_nxt_s   = bus.obs_addr;
                        stride_nxt_s = delta_s;
                        conf_nxt_s   = CONF_ONE;
                    end
                end
                ST_LOCKED: begin
                    if (id_miss_s || far_s) begin
                        // Stream lost entirely: tell the controller, start over
                        state_nxt_s  = ST_FIRST;
                        tag_nxt_s    = bus.obs_id;
                        base_nxt_s   = bus.obs_addr;
                        stride_nxt_s = ADDR_ZERO;
                        conf_nxt_s   = CONF_ZERO;
                        chg_nxt_s    = 1'b1;
                    end else if (zero_s) begin
                        state_nxt_s = ST_LOCKED;
                    end else if (match_s) begin
                        state_nxt_s = ST_LOCKED;
                        base_nxt_s  = bus.obs_addr;
                        conf_nxt_s  = conf_inc_s;
                    end else begin
                        // Same stream, new stride: retrain from the new delta
                        state_nxt_s  = ST_TRAIN;
                        base_nxt_s   = bus.obs_addr;
                        stride_nxt_s = delta_s;
                        conf_nxt_s   = CONF_ONE;
                        chg_nxt_s    = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s  = ST_IDLE;
                    tag_nxt_s    = {TID_WIDTH{1'b0}};
                    base_nxt_s   = ADDR_ZERO;
                    stride_nxt_s = ADDR_ZERO;
                    conf_nxt_s   = CONF_ZERO;
                end
            endcase
        end else begin
            // No observation this cycle: context holds
            state_nxt_s = state_r;
        end
    end

    // Context registers: reset, then flush, then enable gating, then training.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r  <= ST_IDLE;
            stride_r <= ADDR_ZERO;
            base_r   <= ADDR_ZERO;
            tag_r    <= {TID_WIDTH{1'b0}};
            conf_r   <= CONF_ZERO;
            chg_r    <= 1'b0;
            ctx_r    <= 1'b0;
            locked_r <= 1'b0;
        end else if (flush) begin
            state_r  <= ST_IDLE;
            stride_r <= ADDR_ZERO;
            base_r   <= ADDR_ZERO;
            tag_r    <= {TID_WIDTH{1'b0}};
            conf_r   <= CONF_ZERO;
            chg_r    <= 1'b0;
            ctx_r    <= 1'b0;
            locked_r <= 1'b0;
        end else if (!en) begin
            chg_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            stride_r <= stride_nxt_s;
            base_r   <= base_nxt_s;
            tag_r    <= tag_nxt_s;
            conf_r   <= conf_nxt_s;
            chg_r    <= chg_nxt_s;
            ctx_r    <= (state_nxt_s != ST_IDLE);
            locked_r <= (state_nxt_s == ST_LOCKED);
        end
    end

    assign bus.ctx_valid     = ctx_r;
    assign bus.stride_locked = locked_r;
    assign bus.stride        = stride_r;
    assign bus.base_addr     = base_r;
    assign bus.tag_id        = tag_r;
    assign bus.conf          = conf_r;
    assign bus.stride_change = chg_r;

endmodule

// File: tb/tb_stride_detector.sv
// Scoreboard bench for stride_detector: directed vectors push hand-computed
// expected outputs; a monitor pops and compares after each active edge.
module tb_stride_detector;

    localparam int AB = 64;
    localparam int TW = 4;
    localparam int CB = 2;

    typedef struct packed {
        logic          ctx;
        logic          lk;
        logic [AB-1:0] str;
        logic [AB-1:0] base;
        logic [TW-1:0] tag;
        logic [CB-1:0] conf;
        logic          chg;
    } exp_t;

    logic clk;
    logic reset_n;
    logic en;
    logic flush;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks_total;
    int    checks_passed;

    stride_detector_if #(.ADDR_BITS(AB), .TID_WIDTH(TW), .CONF_BITS(CB)) sd_if ();

    stride_detector #(
        .ADDR_BITS(AB), .TID_WIDTH(TW), .CONF_BITS(CB),
        .CONF_THRESH(3), .MAX_STRIDE(4096)
    ) dut (
        .clk(clk), .resetN(reset_n), .en(en), .flush(flush), .bus(sd_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t ex(input logic ctx, input logic lk, input logic [AB-1:0] str,
                                input logic [AB-1:0] base, input logic [TW-1:0] tag,
                                input logic [CB-1:0] conf, input logic chg);
        exp_t e;
        e.ctx = ctx; e.lk = lk; e.str = str; e.base = base;
        e.tag = tag; e.conf = conf; e.chg = chg;
        return e;
    endfunction

    // Drive one cycle of inputs and queue the response expected after the edge.
    task automatic step(input logic rn, input logic e, input logic f, input logic v,
                        input logic [AB-1:0] a, input logic [TW-1:0] id,
                        input exp_t x, input string nm);
        @(negedge clk);
        reset_n = rn; en = e; flush = f;
        sd_if.obs_valid = v; sd_if.obs_addr = a; sd_if.obs_id = id;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    // Monitor: compare DUT outputs against the scoreboard after each edge.
    always @(posedge clk) begin
        exp_t  act;
        exp_t  want;
        string nm;
        #2;
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            act  = ex(sd_if.ctx_valid, sd_if.stride_locked, sd_if.stride, sd_if.base_addr,
                      sd_if.tag_id, sd_if.conf, sd_if.stride_change);
            checks_total++;
            if (act === want) begin
                checks_passed++;
            end else begin
                $display("FAIL %s: got ctx=%0b lk=%0b stride=%h base=%h tag=%0d conf=%0d chg=%0b; expected ctx=%0b lk=%0b stride=%h base=%h tag=%0d conf=%0d chg=%0b",
                         nm, act.ctx, act.lk, act.str, act.base, act.tag, act.conf, act.chg,
                         want.ctx, want.lk, want.str, want.base, want.tag, want.conf, want.chg);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    localparam logic [AB-1:0] NEG40  = 64'hFFFF_FFFF_FFFF_FFC0;
    localparam logic [AB-1:0] HI80   = 64'hFFFF_FFFF_FFFF_FF80;
    localparam logic [AB-1:0] NEGFAR = 64'hFFFF_FFFF_FFFF_E130;
    localparam exp_t ZERO = '0;

    initial begin
        checks_total = 0; checks_passed = 0;
        reset_n = 1'b0; en = 1'b1; flush = 1'b0;
        sd_if.obs_valid = 1'b0; sd_if.obs_addr = 64'h0; sd_if.obs_id = 4'h0;

        step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 4'd0, ZERO, "reset");
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 4'd0, ZERO, "idle_after_reset");
        // Lock on +0x40, then saturate
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h100, 4'd2, ex(1'b1, 1'b0, 64'h0,  64'h100, 4'd2, 2'd0, 1'b0), "lock_first");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h140, 4'd2, ex(1'b1, 1'b0, 64'h40, 64'h140, 4'd2, 2'd1, 1'b0), "lock_train1");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h180, 4'd2, ex(1'b1, 1'b0, 64'h40, 64'h180, 4'd2, 2'd2, 1'b0), "lock_train2");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h1C0, 4'd2, ex(1'b1, 1'b1, 64'h40, 64'h1C0, 4'd2, 2'd3, 1'b0), "lock_locked");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h200, 4'd2, ex(1'b1, 1'b1, 64'h40, 64'h200, 4'd2, 2'd3, 1'b0), "sat_4");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h240, 4'd2, ex(1'b1, 1'b1, 64'h40, 64'h240, 4'd2, 2'd3, 1'b0), "sat_5");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h280, 4'd2, ex(1'b1, 1'b1, 64'h40, 64'h280, 4'd2, 2'd3, 1'b0), "sat_6");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h280, 4'd2, ex(1'b1, 1'b1, 64'h40, 64'h280, 4'd2, 2'd3, 1'b0), "locked_delta0");
        step(1'b1, 1'b0, 1'b0, 1'b1, 64'h9000, 4'd7, ex(1'b1, 1'b1, 64'h40, 64'h280, 4'd2, 2'd3, 1'b0), "en_low_obs");
        step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 4'd0, ex(1'b1, 1'b1, 64'h40, 64'h280, 4'd2, 2'd3, 1'b0), "en_low_idle");
        // Break with a new stride
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h300, 4'd2, ex(1'b1, 1'b0, 64'h80, 64'h300, 4'd2, 2'd1, 1'b1), "break_pulse");
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 4'd0, ex(1'b1, 1'b0, 64'h80, 64'h300, 4'd2, 2'd1, 1'b0), "break_pulse_end");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h380, 4'd2, ex(1'b1, 1'b0, 64'h80, 64'h380, 4'd2, 2'd2, 1'b0), "retrain");
        // Foreign ID and far jumps
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h9000, 4'd5, ex(1'b1, 1'b0, 64'h0, 64'h9000, 4'd5, 2'd0, 1'b0), "train_foreign");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h9100, 4'd5, ex(1'b1, 1'b0, 64'h100, 64'h9100, 4'd5, 2'd1, 1'b0), "id5_train");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'hB100, 4'd5, ex(1'b1, 1'b0, 64'h0, 64'hB100, 4'd5, 2'd0, 1'b0), "train_far");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'hB100, 4'd5, ex(1'b1, 1'b0, 64'h0, 64'hB100, 4'd5, 2'd0, 1'b0), "first_delta0");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h100000, 4'd5, ex(1'b1, 1'b0, 64'h0, 64'h100000, 4'd5, 2'd0, 1'b0), "first_far");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h100040, 4'd3, ex(1'b1, 1'b0, 64'h0, 64'h100040, 4'd3, 2'd0, 1'b0), "first_foreign");
        step(1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 4'd0, ZERO, "flush");
        // Negative stride, then flush colliding with an observation
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h1000, 4'd2, ex(1'b1, 1'b0, 64'h0,  64'h1000, 4'd2, 2'd0, 1'b0), "neg_first");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'hFC0,  4'd2, ex(1'b1, 1'b0, NEG40, 64'hFC0,  4'd2, 2'd1, 1'b0), "neg_train1");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'hF80,  4'd2, ex(1'b1, 1'b0, NEG40, 64'hF80,  4'd2, 2'd2, 1'b0), "neg_train2");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'hF40,  4'd2, ex(1'b1, 1'b1, NEG40, 64'hF40,  4'd2, 2'd3, 1'b0), "neg_locked");
        step(1'b1, 1'b1, 1'b1, 1'b1, 64'hF00,  4'd2, ZERO, "flush_collision");
        // Wrap-around across 2^64
        step(1'b1, 1'b1, 1'b0, 1'b1, HI80,  4'd1, ex(1'b1, 1'b0, 64'h0,  HI80,  4'd1, 2'd0, 1'b0), "wrap_first");
        step(1'b1, 1'b1, 1'b0, 1'b1, NEG40, 4'd1, ex(1'b1, 1'b0, 64'h40, NEG40, 4'd1, 2'd1, 1'b0), "wrap_train1");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h0, 4'd1, ex(1'b1, 1'b0, 64'h40, 64'h0, 4'd1, 2'd2, 1'b0), "wrap_cross");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h40, 4'd1, ex(1'b1, 1'b1, 64'h40, 64'h40, 4'd1, 2'd3, 1'b0), "wrap_locked");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h10000, 4'd1, ex(1'b1, 1'b0, 64'h0, 64'h10000, 4'd1, 2'd0, 1'b1), "locked_far");
        // MAX_STRIDE boundary
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h10010, 4'd1, ex(1'b1, 1'b0, 64'h10,   64'h10010, 4'd1, 2'd1, 1'b0), "bnd_train");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h11010, 4'd1, ex(1'b1, 1'b0, 64'h1000, 64'h11010, 4'd1, 2'd1, 1'b0), "bnd_4096_ok");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h12011, 4'd1, ex(1'b1, 1'b0, 64'h0,    64'h12011, 4'd1, 2'd0, 1'b0), "bnd_4097_far");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h12021, 4'd1, ex(1'b1, 1'b0, 64'h10, 64'h12021, 4'd1, 2'd1, 1'b0), "relock1");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h12031, 4'd1, ex(1'b1, 1'b0, 64'h10, 64'h12031, 4'd1, 2'd2, 1'b0), "relock2");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h12041, 4'd1, ex(1'b1, 1'b1, 64'h10, 64'h12041, 4'd1, 2'd3, 1'b0), "relock3");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h500, 4'd4, ex(1'b1, 1'b0, 64'h0, 64'h500, 4'd4, 2'd0, 1'b1), "locked_foreign");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h510, 4'd4, ex(1'b1, 1'b0, 64'h10, 64'h510, 4'd4, 2'd1, 1'b0), "id4_train1");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h520, 4'd4, ex(1'b1, 1'b0, 64'h10, 64'h520, 4'd4, 2'd2, 1'b0), "id4_train2");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h530, 4'd4, ex(1'b1, 1'b1, 64'h10, 64'h530, 4'd4, 2'd3, 1'b0), "id4_locked");
        step(1'b1, 1'b0, 1'b1, 1'b1, 64'h540, 4'd4, ZERO, "flush_over_en_low");
        // Reset while locked
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h600, 4'd4, ex(1'b1, 1'b0, 64'h0,  64'h600, 4'd4, 2'd0, 1'b0), "rst_first");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h610, 4'd4, ex(1'b1, 1'b0, 64'h10, 64'h610, 4'd4, 2'd1, 1'b0), "rst_train1");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h620, 4'd4, ex(1'b1, 1'b0, 64'h10, 64'h620, 4'd4, 2'd2, 1'b0), "rst_train2");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h630, 4'd4, ex(1'b1, 1'b1, 64'h10, 64'h630, 4'd4, 2'd3, 1'b0), "rst_locked");
        step(1'b0, 1'b1, 1'b1, 1'b1, 64'h640, 4'd4, ZERO, "reset_mid_locked");
        // en low mid-train resumes on the same state
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h100, 4'd2, ex(1'b1, 1'b0, 64'h0,  64'h100, 4'd2, 2'd0, 1'b0), "en_first");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h110, 4'd2, ex(1'b1, 1'b0, 64'h10, 64'h110, 4'd2, 2'd1, 1'b0), "en_train1");
        step(1'b1, 1'b0, 1'b0, 1'b1, 64'h120, 4'd2, ex(1'b1, 1'b0, 64'h10, 64'h110, 4'd2, 2'd1, 1'b0), "en_low_train");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h120, 4'd2, ex(1'b1, 1'b0, 64'h10, 64'h120, 4'd2, 2'd2, 1'b0), "en_resume");
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h130, 4'd2, ex(1'b1, 1'b1, 64'h10, 64'h130, 4'd2, 2'd3, 1'b0), "en_locked");
        step(1'b1, 1'b1, 1'b0, 1'b1, NEGFAR, 4'd2, ex(1'b1, 1'b0, 64'h0, NEGFAR, 4'd2, 2'd0, 1'b1), "locked_neg_far");
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 4'd0, ex(1'b1, 1'b0, 64'h0, NEGFAR, 4'd2, 2'd0, 1'b0), "final_hold");

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() != 0) begin
                @(negedge clk);
            end
        end
        if (exp_q.size() != 0) begin
            checks_total++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
